fetch_unit: RTL and testbench

Instruction fetch stage of the Core101 pipeline, directly upstream of the decode unit. Holds the fetch PC, issues one word-aligned request at a time to instruction memory over a valid/ready handshake, and buffers returned words with their PCs in a small FIFO. Presents the head instruction to decode, with opcode/funct3/funct7 pre-sliced, under a valid/ready handshake. Accepts redirects (jump/branch target) from the execute stage, which flush the buffer and squash any in-flight response.

---
 rtl/core101_fetch_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_fetch_pkg.sv
// Shared definitions for the Core101 fetch stage: state encoding, instruction
// field positions (also used by decode), the buffer entry payload and the
// default reset PC.
package core101_fetch_pkg;

  localparam int unsigned FETCH_XLEN       = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions, shared with the decode unit
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  // One buffered instruction with the PC it was fetched from
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, ins} entries between fetch and decode.
// Ports:
//   clk_in, rst_in      clock, synchronous active-high reset
//   push_in/entry_in    write one entry (ignored when full)
//   pop_in              drop the head entry (ignored when empty)
//   flush_in            empty the FIFO; dominates push/pop
//   count_out           number of valid entries
//   head_out            oldest entry (all-zero after reset)
module fetch_buffer
  import core101_fetch_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  fetch_entry_t     entry_in,
  input  logic             pop_in,
  input  logic             flush_in,
  output logic [CNT_W-1:0] count_out,
  output fetch_entry_t     head_out
);

  fetch_entry_t     entries_q [BUF_DEPTH];
  fetch_entry_t     entries_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Circular pointer advance with wrap at BUF_DEPTH
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign do_push = push_in && (count_q != CNT_W'(BUF_DEPTH));
  assign do_pop  = pop_in && (count_q != '0);

  // Next-state for storage, pointers and occupancy
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        entries_d[wr_ptr_q] = entry_in;
        wr_ptr_d            = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      entries_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign count_out = count_q;
  assign head_out  = entries_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Core101 instruction fetch stage. Issues one word-aligned request at a time
// to instruction memory, buffers returned words with their PCs and presents
// the head to decode with opcode/funct3/funct7 pre-sliced. A redirect flushes
// the buffer and squashes any response still owed by memory.
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   fet_mem_req_valid/ready/addr   memory request handshake
//   fet_mem_rsp_valid/data         memory response (>=1 cycle after accept)
//   fet_redirect_in/pc_in          jump/branch redirect from execute
//   fet_ins_valid/ready            decode handshake
//   fet_ins/pc/opcode/funct3/funct7  head instruction and its fields
module fetch_unit
  import core101_fetch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic            fet_mem_req_valid_out,
  input  logic            fet_mem_req_ready_in,
  output logic [XLEN-1:0] fet_mem_addr_out,
  input  logic            fet_mem_rsp_valid_in,
  input  logic [XLEN-1:0] fet_mem_rsp_data_in,
  input  logic            fet_redirect_in,
  input  logic [XLEN-1:0] fet_redirect_pc_in,
  output logic            fet_ins_valid_out,
  input  logic            fet_ins_ready_in,
  output logic [XLEN-1:0] fet_ins_out,
  output logic [XLEN-1:0] fet_pc_out,
  output logic [6:0]      fet_opcode_out,
  output logic [2:0]      fet_funct3_out,
  output logic [6:0]      fet_funct7_out
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             req_valid;
  logic             accept;
  logic             rsp_take;
  logic             ins_valid;
  logic             push;
  logic             pop;
  logic             unused_redirect_lsbs;

  // Target is always word-aligned; the low bits are don't-care
  assign unused_redirect_lsbs = ^fet_redirect_pc_in[1:0];

  // Handshake qualifiers; redirect and reset withdraw both valids
  assign req_valid = (state_q == S_REQ) && (count < CNT_W'(BUF_DEPTH))
                     && !fet_redirect_in && !rst_in;
  assign accept    = req_valid && fet_mem_req_ready_in;
  assign rsp_take  = (state_q == S_WAIT) && fet_mem_rsp_valid_in;
  assign ins_valid = (count != '0) && !fet_redirect_in && !rst_in;
  assign pop       = ins_valid && fet_ins_ready_in;
  assign push      = rsp_take && !drop_q && !fet_redirect_in;
  assign push_entry = '{pc: req_pc_q, ins: fet_mem_rsp_data_in};

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push_in   (push),
    .entry_in  (push_entry),
    .pop_in    (pop),
    .flush_in  (fet_redirect_in),
    .count_out (count),
    .head_out  (head)
  );

  // Request FSM and PC tracking; redirect takes priority over everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if (fet_redirect_in) begin
      fetch_pc_d = {fet_redirect_pc_in[XLEN-1:2], 2'b00};
      if ((state_q == S_WAIT) && !fet_mem_rsp_valid_in) begin
        // Memory still owes a word for the old path; swallow it when it lands
        drop_d = 1'b1;
      end else begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_take) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign fet_mem_req_valid_out = req_valid;
  assign fet_mem_addr_out      = fetch_pc_q;
  assign fet_ins_valid_out     = ins_valid;
  assign fet_ins_out           = head.ins;
  assign fet_pc_out            = head.pc;
  assign fet_opcode_out        = head.ins[OPCODE_LSB +: OPCODE_W];
  assign fet_funct3_out        = head.ins[FUNCT3_LSB +: FUNCT3_W];
  assign fet_funct7_out        = head.ins[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run, all
// checked against a transaction-level model (expected PC stream + queue of
// buffered instructions) and a latency-programmable memory model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        fet_mem_req_valid_out;
  logic        fet_mem_req_ready_in;
  logic [31:0] fet_mem_addr_out;
  logic        fet_mem_rsp_valid_in;
  logic [31:0] fet_mem_rsp_data_in;
  logic        fet_redirect_in;
  logic [31:0] fet_redirect_pc_in;
  logic        fet_ins_valid_out;
  logic        fet_ins_ready_in;
  logic [31:0] fet_ins_out;
  logic [31:0] fet_pc_out;
  logic [6:0]  fet_opcode_out;
  logic [2:0]  fet_funct3_out;
  logic [6:0]  fet_funct7_out;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN      (32),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk_in                (clk),
    .rst_in                (rst_in),
    .fet_mem_req_valid_out (fet_mem_req_valid_out),
    .fet_mem_req_ready_in  (fet_mem_req_ready_in),
    .fet_mem_addr_out      (fet_mem_addr_out),
    .fet_mem_rsp_valid_in  (fet_mem_rsp_valid_in),
    .fet_mem_rsp_data_in   (fet_mem_rsp_data_in),
    .fet_redirect_in       (fet_redirect_in),
    .fet_redirect_pc_in    (fet_redirect_pc_in),
    .fet_ins_valid_out     (fet_ins_valid_out),
    .fet_ins_ready_in      (fet_ins_ready_in),
    .fet_ins_out           (fet_ins_out),
    .fet_pc_out            (fet_pc_out),
    .fet_opcode_out        (fet_opcode_out),
    .fet_funct3_out        (fet_funct3_out),
    .fet_funct7_out        (fet_funct7_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, one outstanding request, and the
  // in-order list of instructions decode should see
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_req_pc = '0;
  bit          m_wait = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_fresh = 1'b1;
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];

  // Memory model
  bit          mem_pend = 1'b0;
  int          mem_left = 0;
  logic [31:0] mem_addr = '0;
  int          lat = 1;

  logic [31:0] acc_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, check outputs mid-cycle, then
  // advance model and memory on the rising edge
  task automatic cycle();
    bit          e_req, e_ins, rsp_now, dut_req;
    logic [31:0] dut_addr, w;
    rsp_now = mem_pend && (mem_left == 1) && !rst_in;
    fet_mem_rsp_valid_in = rsp_now;
    fet_mem_rsp_data_in  = rsp_now ? mem_word(mem_addr) : $urandom;
    #4;
    e_req = !rst_in && !m_wait && (q_pc.size() < DEPTH) && !fet_redirect_in;
    e_ins = !rst_in && (q_pc.size() != 0) && !fet_redirect_in;
    chk("req_valid", 32'(fet_mem_req_valid_out), 32'(e_req));
    if (e_req) chk("req_addr", fet_mem_addr_out, m_pc);
    chk("ins_valid", 32'(fet_ins_valid_out), 32'(e_ins));
    if (e_ins) begin
      w = q_ins[0];
      chk("ins", fet_ins_out, w);
      chk("pc", fet_pc_out, q_pc[0]);
      chk("opcode", 32'(fet_opcode_out), w & 32'h7F);
      chk("funct3", 32'(fet_funct3_out), (w >> 12) & 32'h7);
      chk("funct7", 32'(fet_funct7_out), w >> 25);
    end else if (m_fresh && !rst_in) begin
      chk("ins_zero", fet_ins_out, 32'h0);
      chk("pc_zero", fet_pc_out, 32'h0);
      chk("fields_zero", {15'd0, fet_funct7_out, fet_funct3_out, fet_opcode_out}, 32'h0);
    end
    dut_req  = fet_mem_req_valid_out;
    dut_addr = fet_mem_addr_out;
    @(posedge clk);
    if (rst_in) begin
      q_pc.delete(); q_ins.delete();
      m_pc = RST_PC; m_wait = 0; m_drop = 0; m_fresh = 1;
    end else if (fet_redirect_in) begin
      q_pc.delete(); q_ins.delete();
      m_pc = fet_redirect_pc_in & ~32'h3;
      if (m_wait && !rsp_now) m_drop = 1;
      else begin m_wait = 0; m_drop = 0; end
    end else begin
      if (e_ins && fet_ins_ready_in) begin
        void'(q_pc.pop_front()); void'(q_ins.pop_front());
      end
      if (m_wait && rsp_now) begin
        if (!m_drop) begin
          q_pc.push_back(m_req_pc); q_ins.push_back(mem_word(m_req_pc)); m_fresh = 0;
        end
        m_wait = 0; m_drop = 0;
      end
      if (e_req && fet_mem_req_ready_in) begin
        m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_wait = 1;
      end
    end
    if (rst_in) mem_pend = 0;
    else begin
      if (mem_pend) begin
        if (rsp_now) mem_pend = 0;
        else mem_left--;
      end
      if (dut_req && fet_mem_req_ready_in && !mem_pend) begin
        mem_pend = 1; mem_left = lat; mem_addr = dut_addr; acc_log.push_back(dut_addr);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
  endtask

  initial begin
    bit hit;
    rst_in = 1'b1; fet_mem_req_ready_in = 1'b1; fet_ins_ready_in = 1'b1;
    fet_redirect_in = 1'b0; fet_redirect_pc_in = '0;
    fet_mem_rsp_valid_in = 1'b0; fet_mem_rsp_data_in = '0;
    repeat (3) cycle();
    rst_in = 1'b0;

    // Streaming with L=1: requests on alternate cycles at 0x0, 0x4, 0x8
    acc_log.delete();
    repeat (8) cycle();
    chk("t1_n_acc", 32'(acc_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3) begin
      chk("t1_acc0", acc_log[0], 32'h0);
      chk("t1_acc1", acc_log[1], 32'h4);
      chk("t1_acc2", acc_log[2], 32'h8);
    end

    // Decode stalled: buffer fills, requests stop, then drain in order
    do_reset();
    fet_ins_ready_in = 1'b0;
    acc_log.delete();
    repeat (12) cycle();
    chk("t2_n_acc", 32'(acc_log.size()), 32'd2);
    fet_ins_ready_in = 1'b1;
    repeat (8) cycle();

    // Memory not ready: request held stable at reset PC
    do_reset();
    fet_mem_req_ready_in = 1'b0;
    repeat (5) begin
      cycle();
      chk("t3_addr_hold", fet_mem_addr_out, RST_PC);
    end
    fet_mem_req_ready_in = 1'b1;
    repeat (4) cycle();

    // Redirect to 0x103 with a request outstanding (L=3)
    do_reset();
    lat = 3;
    cycle();
    fet_redirect_in = 1'b1; fet_redirect_pc_in = 32'h0000_0103;
    cycle();
    fet_redirect_in = 1'b0;
    acc_log.delete();
    repeat (12) cycle();
    chk("t4_n_acc", 32'(acc_log.size() >= 1), 32'd1);
    if (acc_log.size() >= 1) chk("t4_target", acc_log[0], 32'h0000_0100);

    // Redirect coinciding with a response and a decode pop
    do_reset();
    lat = 2; fet_ins_ready_in = 1'b0; hit = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_pend && mem_left == 1 && q_pc.size() > 0) begin
        fet_redirect_in = 1'b1; fet_redirect_pc_in = 32'h0000_2000; fet_ins_ready_in = 1'b1;
        cycle();
        fet_redirect_in = 1'b0;
        hit = 1;
        break;
      end
      cycle();
    end
    chk("t5_hit", 32'(hit), 32'd1);
    acc_log.delete();
    cycle();
    chk("t5_n_acc", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() == 1) chk("t5_target", acc_log[0], 32'h0000_2000);
    repeat (4) cycle();

    // Reset with a full buffer, then reset while a response is owed
    do_reset();
    lat = 1; fet_ins_ready_in = 1'b0;
    repeat (6) cycle();
    chk("t6_full", 32'(q_pc.size()), 32'(DEPTH));
    do_reset();
    acc_log.delete();
    fet_ins_ready_in = 1'b1;
    cycle();
    chk("t6_n_acc", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() == 1) chk("t6_rst_pc", acc_log[0], RST_PC);
    lat = 4;
    repeat (2) cycle();
    do_reset();
    repeat (6) cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      fet_mem_req_ready_in = ($urandom_range(0, 3) != 0);
      fet_ins_ready_in     = ($urandom_range(0, 2) != 0);
      fet_redirect_in      = ($urandom_range(0, 19) == 0);
      fet_redirect_pc_in   = $urandom;
      rst_in               = ($urandom_range(0, 99) == 0);
      if (!mem_pend) lat = $urandom_range(1, 4);
      cycle();
    end
    rst_in = 1'b0; fet_redirect_in = 1'b0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
